// File: rtl/alu_div_sequencer_if.sv
// Request/response handshake between the decode/execute stage and the
// divide sequencer. The requester (decode/execute) uses the master modport,
// the sequencer uses the slave modport.
interface alu_div_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_div_zero;

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero
    );

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle 32-bit divide controller. Every arithmetic step (sign
// stripping, restoring-division trial subtract, sign restoration) goes
// through the shared ALU; the sequencer only drives the ALU while busy.
// Fixed latency: 1 (PRE_N) + 1 (PRE_D) + 32 (DIV) + 1 (POST_Q) + 1 (POST_R)
// cycles after the accepting edge, then DONE holds the result.
module alu_div_sequencer #(
    parameter logic [7:0] OP_SUB  = 8'd2,
    parameter logic [7:0] OP_PASS = 8'd9
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_div_sequencer_if.slave       dif,
    output logic                     busy,
    output logic [7:0]               alu_op,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic                     alu_carry_in,
    input  logic [31:0]              alu_c,
    input  logic                     alu_carry_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE_N  = 3'd1,
        ST_PRE_D  = 3'd2,
        ST_DIV    = 3'd3,
        ST_POST_Q = 3'd4,
        ST_POST_R = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] quot_q, quot_d;   // dividend, then |dividend| shifting into quotient
    logic [31:0] rem_q, rem_d;     // partial remainder
    logic [31:0] dsr_q, dsr_d;     // divisor, then |divisor|
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_n_q, neg_n_d;
    logic        neg_d_q, neg_d_d;
    logic        zero_q, zero_d;

    logic [31:0] shift_s;
    logic        accept_s;

    // Next-state, datapath update and ALU operand selection
    always_comb begin
        state_d  = state_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        neg_n_d  = neg_n_q;
        neg_d_d  = neg_d_q;
        zero_d   = zero_q;
        alu_op   = OP_PASS;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        shift_s  = {rem_q[30:0], quot_q[31]};
        accept_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dif.req_valid) begin
                    quot_d  = dif.req_dividend;
                    dsr_d   = dif.req_divisor;
                    neg_n_d = dif.req_signed & dif.req_dividend[31];
                    neg_d_d = dif.req_signed & dif.req_divisor[31];
                    zero_d  = (dif.req_divisor == 32'd0);
                    state_d = ST_PRE_N;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE_N: begin
                if (neg_n_q) begin
                    alu_op = OP_SUB;
                    alu_b  = quot_q;
                end else begin
                    alu_a  = quot_q;
                end
                quot_d  = alu_c;
                state_d = ST_PRE_D;
            end
            ST_PRE_D: begin
                if (neg_d_q) begin
                    alu_op = OP_SUB;
                    alu_b  = dsr_q;
                end else begin
                    alu_a  = dsr_q;
                end
                dsr_d   = alu_c;
                rem_d   = 32'd0;
                cnt_d   = 5'd0;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                // A set R[31] means the shifted value needs 33 bits, so it
                // certainly exceeds D and the low 32 bits of the ALU result
                // are still the correct difference.
                alu_op   = OP_SUB;
                alu_a    = shift_s;
                alu_b    = dsr_q;
                accept_s = rem_q[31] | ~alu_carry_out;
                if (accept_s) begin
                    rem_d  = alu_c;
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shift_s;
                    quot_d = {quot_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    state_d = ST_POST_Q;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            ST_POST_Q: begin
                // Divide-by-zero keeps the all-ones quotient unnegated.
                if ((neg_n_q ^ neg_d_q) & ~zero_q) begin
                    alu_op = OP_SUB;
                    alu_b  = quot_q;
                end else begin
                    alu_a  = quot_q;
                end
                quot_d  = alu_c;
                state_d = ST_POST_R;
            end
            ST_POST_R: begin
                if (neg_n_q) begin
                    alu_op = OP_SUB;
                    alu_b  = rem_q;
                end else begin
                    alu_a  = rem_q;
                end
                rem_d   = alu_c;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (dif.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dsr_q   <= 32'd0;
            cnt_q   <= 5'd0;
            neg_n_q <= 1'b0;
            neg_d_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            neg_n_q <= neg_n_d;
            neg_d_q <= neg_d_d;
            zero_q  <= zero_d;
        end
    end

    assign dif.req_ready     = (state_q == ST_IDLE);
    assign dif.rsp_valid     = (state_q == ST_DONE);
    assign dif.rsp_quotient  = quot_q;
    assign dif.rsp_remainder = rem_q;
    assign dif.rsp_div_zero  = zero_q;
    assign busy              = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign alu_carry_in      = 1'b0;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: models the shared ALU, drives directed and
// random divides, and compares against an arithmetic reference.
module tb_alu_div_sequencer;

    localparam logic [7:0] OP_SUB  = 8'd2;
    localparam logic [7:0] OP_PASS = 8'd9;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [7:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_carry_in;
    logic [31:0] alu_c;
    logic        alu_carry_out;

    int n_pass;
    int n_total;

    alu_div_sequencer_if dif();

    alu_div_sequencer #(.OP_SUB(OP_SUB), .OP_PASS(OP_PASS)) dut (
        .clk           (clk),
        .reset         (reset),
        .dif           (dif.slave),
        .busy          (busy),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_c         (alu_c),
        .alu_carry_out (alu_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU behaviour: subtract with borrow out, or pass a through
    always_comb begin
        alu_c         = alu_a;
        alu_carry_out = 1'b0;
        case (alu_op)
            OP_SUB: begin
                alu_c         = alu_a - alu_b;
                alu_carry_out = (alu_a < alu_b);
            end
            default: begin
                alu_c         = alu_a;
                alu_carry_out = 1'b0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: truncating division, remainder follows dividend sign
    task automatic ref_div(input logic s, input logic [31:0] n, input logic [31:0] d,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        int sn;
        int sd;
        z = (d == 32'd0);
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
        end else if (!s) begin
            q = n / d;
            r = n % d;
        end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sn = n;
            sd = d;
            q = sn / sd;
            r = sn % sd;
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send(input logic s, input logic [31:0] n, input logic [31:0] d);
        dif.req_valid    = 1'b1;
        dif.req_signed   = s;
        dif.req_dividend = n;
        dif.req_divisor  = d;
        check("req_ready_before_accept", {31'd0, dif.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        dif.req_valid = 1'b0;
    endtask

    // Waits for the response, checks latency and data, optionally releases it
    task automatic collect(input string tag, input logic s, input logic [31:0] n,
                           input logic [31:0] d, input bit release_rsp);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int cycles;
        ref_div(s, n, d, eq, er, ez);
        cycles = 1;
        while (!dif.rsp_valid && cycles < 100) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, 32'd37);
        check({tag, "_q"}, dif.rsp_quotient, eq);
        check({tag, "_r"}, dif.rsp_remainder, er);
        check({tag, "_dz"}, {31'd0, dif.rsp_div_zero}, {31'd0, ez});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        if (release_rsp) begin
            dif.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dif.rsp_ready = 1'b0;
            check({tag, "_rsp_drop"}, {31'd0, dif.rsp_valid}, 32'd0);
        end
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] n, input logic [31:0] d);
        send(s, n, d);
        collect(tag, s, n, d, 1'b1);
    endtask

    initial begin
        logic [31:0] hold_q;
        logic [31:0] hold_r;
        logic [31:0] rn;
        logic [31:0] rd;
        logic        rs;
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        dif.req_valid    = 1'b0;
        dif.req_signed   = 1'b0;
        dif.req_dividend = 32'd0;
        dif.req_divisor  = 32'd0;
        dif.rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, dif.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_q", dif.rsp_quotient, 32'd0);
        check("rst_r", dif.rsp_remainder, 32'd0);
        check("rst_alu_op", {24'd0, alu_op}, {24'd0, OP_PASS});
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run("u100_7",     1'b0, 32'd100,         32'd7);
        run("uffff_1",    1'b0, 32'hFFFF_FFFF,   32'd1);
        run("u8001_8000", 1'b0, 32'h8000_0001,   32'h8000_0000);
        run("s_m7_2",     1'b1, 32'hFFFF_FFF9,   32'd2);
        run("s_7_m2",     1'b1, 32'd7,           32'hFFFF_FFFE);
        run("s_ovf",      1'b1, 32'h8000_0000,   32'hFFFF_FFFF);
        run("u_dz",       1'b0, 32'd1234,        32'd0);
        run("s_dz",       1'b1, 32'hFFFF_FFFB,   32'd0);
        check("idle_alu_op", {24'd0, alu_op}, {24'd0, OP_PASS});
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_alu_cin", {31'd0, alu_carry_in}, 32'd0);

        // Backpressure then back-to-back request
        send(1'b0, 32'd1000, 32'd33);
        collect("bp", 1'b0, 32'd1000, 32'd33, 1'b0);
        hold_q = dif.rsp_quotient;
        hold_r = dif.rsp_remainder;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'd0, dif.rsp_valid}, 32'd1);
            check("bp_ready", {31'd0, dif.req_ready}, 32'd0);
            check("bp_q_stable", dif.rsp_quotient, hold_q);
            check("bp_r_stable", dif.rsp_remainder, hold_r);
        end
        dif.rsp_ready    = 1'b1;
        dif.req_valid    = 1'b1;
        dif.req_signed   = 1'b1;
        dif.req_dividend = 32'hFFFF_FC18;
        dif.req_divisor  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        dif.rsp_ready = 1'b0;
        check("b2b_ready", {31'd0, dif.req_ready}, 32'd1);
        check("b2b_rsp_drop", {31'd0, dif.rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        dif.req_valid = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        collect("b2b", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b1);

        // Reset during DIV k=10 aborts
        send(1'b0, 32'd5555, 32'd3);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", {31'd0, dif.req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_no_rsp", {31'd0, dif.rsp_valid}, 32'd0);
        run("after_abort", 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF3);

        // Random operands
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            rn = $urandom;
            case ($urandom_range(0, 3))
                0: rd = $urandom_range(1, 20);
                1: rd = $urandom;
                2: rd = 32'd0;
                default: rd = 32'($urandom_range(0, 65535)) | 32'hFFFF_0000;
            endcase
            run("rand", rs, rn, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
